// File: rtl/memory_instr_issuer.sv
// memory_instr_issuer: fetches program words, runs scalar control ops and forwards memory ops to `memory`.
module memory_instr_issuer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PROGRAM_DEPTH     = 256,
    parameter int REG_WIDTH         = 16,
    parameter int MEM_STALL         = 0,
    localparam int PC_WIDTH         = $clog2(PROGRAM_DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    output logic [PC_WIDTH-1:0]          prog_addr_out,
    input  logic [INSTRUCTION_WIDTH-1:0] prog_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instr_out,
    output logic                         instr_valid_out,
    output logic                         busy_out,
    output logic                         done_out
);
    localparam int SW = MEM_STALL > 0 ? $clog2(MEM_STALL + 1) : 1;
    localparam logic [3:0] OP_END  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_BGE  = 4'b0100;
    localparam logic [3:0] OP_JUMP = 4'b0101;

    typedef enum logic [2:0] {IDLE, F0, F1, F2, EX, STALL, DONE} state_t;

    state_t                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic                           cmp_q, cmp_d;
    logic [REG_WIDTH-1:0]           regs_q [16];
    logic [REG_WIDTH-1:0]           regs_d [16];
    logic [31:4]                    ir_q, ir_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic                           valid_q, valid_d;
    logic [SW-1:0]                  cnt_q, cnt_d;
    logic [3:0]                     op, ra, rb;
    logic [15:0]                    imm;
    logic                           launch;

    function automatic logic is_mem(input logic [3:0] o);
        return o inside {4'b0110, 4'b0111, 4'b1110, 4'b1010, 4'b1100};
    endfunction

    assign op     = ir_q[31:28];
    assign ra     = ir_q[27:24];
    assign imm    = ir_q[23:8];
    assign rb     = ir_q[7:4];
    assign launch = (state_q == IDLE || state_q == DONE) && start_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cmp_q   <= 1'b0;
            regs_q  <= '{default: '0};
            ir_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmp_q   <= cmp_d;
            regs_q  <= regs_d;
            ir_q    <= ir_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start_in ? F0 : state_q;
            F0:         state_d = F1;
            F1:         state_d = F2;
            F2:         state_d = EX;
            EX:         state_d = op == OP_END ? DONE : (is_mem(op) && MEM_STALL > 0) ? STALL : F0;
            STALL:      state_d = cnt_q == '0 ? F0 : STALL;
            default:    state_d = IDLE;
        endcase
    end

    // The output register loads at the F2->EX edge so the pulse lines up exactly with EX.
    always_comb begin
        pc_d    = launch ? '0 : pc_q;
        cmp_d   = launch ? 1'b0 : cmp_q;
        regs_d  = regs_q;
        ir_d    = state_q == F2 ? prog_data_in[31:4] : ir_q;
        valid_d = state_q == F2 && is_mem(prog_data_in[31:28]);
        instr_d = valid_d ? prog_data_in : instr_q;
        cnt_d   = state_q == STALL ? cnt_q - SW'(1) : cnt_q;
        if (state_q == EX) begin
            pc_d  = pc_q + PC_WIDTH'(1);
            cnt_d = SW'(MEM_STALL - 1);
            case (op)
                OP_XOR:  regs_d[ra] = regs_q[ra] ^ regs_q[rb];
                OP_ADDI: regs_d[ra] = regs_q[rb] + REG_WIDTH'(imm);
                OP_BGE:  cmp_d = regs_q[ra] >= regs_q[rb];
                OP_JUMP: pc_d = cmp_q ? imm[PC_WIDTH-1:0] : pc_d;
                default: ;
            endcase
        end
    end

    always_comb begin
        prog_addr_out   = pc_q;
        instr_out       = instr_q;
        instr_valid_out = valid_q;
        busy_out        = !(state_q == IDLE || state_q == DONE);
        done_out        = state_q == DONE;
    end
endmodule

// File: tb/tb_memory_instr_issuer.sv
// tb_memory_instr_issuer: scoreboard bench; an ISA-level interpreter predicts every forwarded op and its cycle.
module tb_memory_instr_issuer;
    logic        clk = 0;
    logic        rst_a = 1, rst_b = 1, st_a = 0, st_b = 0;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] pd_a, pd_b, d1_a, d1_b, io_a, io_b;
    logic        v_a, v_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] prog_a [256];
    logic [31:0] prog_b [256];
    logic [15:0] mr [2][16];
    int          cyc = 0, errs = 0, checks = 0;
    int          base [2], end_cyc [2];
    int          pa[$], pb[$];
    logic        pva = 0, pvb = 0;

    typedef struct packed {logic [31:0] ins; int cyc;} exp_t;
    exp_t qa[$], qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Two-cycle registered program BRAM per DUT.
    always @(posedge clk) begin
        d1_a <= prog_a[addr_a];
        pd_a <= d1_a;
        d1_b <= prog_b[addr_b];
        pd_b <= d1_b;
    end

    memory_instr_issuer #(.MEM_STALL(0)) u_a (
        .clk_in(clk), .rst_in(rst_a), .start_in(st_a), .prog_addr_out(addr_a), .prog_data_in(pd_a),
        .instr_out(io_a), .instr_valid_out(v_a), .busy_out(busy_a), .done_out(done_a));
    memory_instr_issuer #(.MEM_STALL(2)) u_b (
        .clk_in(clk), .rst_in(rst_b), .start_in(st_b), .prog_addr_out(addr_b), .prog_data_in(pd_b),
        .instr_out(io_b), .instr_valid_out(v_b), .busy_out(busy_b), .done_out(done_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] op);
        return op inside {4'h6, 4'h7, 4'hE, 4'hA, 4'hC};
    endfunction

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] a, input logic [15:0] imm, input logic [3:0] b);
        return {op, a, imm, b, 4'h0};
    endfunction

    always @(negedge clk) begin
        if (v_a) begin
            check("a_back_to_back", pva, 0);
            if (qa.size() == 0) begin
                checks++; errs++;
                $display("FAIL a_extra_pulse: got %h expected none", io_a);
            end else begin
                ea = qa.pop_front();
                check("a_instr", io_a, ea.ins);
                check("a_cycle", cyc, ea.cyc);
            end
            pa.push_back(cyc);
        end
        pva = v_a;
        if (v_b) begin
            check("b_back_to_back", pvb, 0);
            if (qb.size() == 0) begin
                checks++; errs++;
                $display("FAIL b_extra_pulse: got %h expected none", io_b);
            end else begin
                eb = qb.pop_front();
                check("b_instr", io_b, eb.ins);
                check("b_cycle", cyc, eb.cyc);
            end
            pb.push_back(cyc);
        end
        pvb = v_b;
    end

    // Instruction-level interpreter: 4 cycles per slot, plus the stall after memory ops.
    task automatic model(input int d, input int maxn);
        int pc = 0, t = 0, stall = d == 0 ? 0 : 2;
        bit cmp = 0;
        logic [31:0] w;
        logic [3:0] op, a, b;
        logic [15:0] imm;
        end_cyc[d] = -1;
        for (int n = 0; n < maxn; n++) begin
            w = d == 0 ? prog_a[pc] : prog_b[pc];
            {op, a, imm, b} = w[31:4];
            if (op == 4'h1) begin
                end_cyc[d] = base[d] + t + 3;
                return;
            end
            if (is_mem(op)) begin
                if (d == 0) qa.push_back('{w, base[d] + t + 3});
                else qb.push_back('{w, base[d] + t + 3});
                t += 4 + stall;
                pc = (pc + 1) % 256;
            end else begin
                if (op == 4'h2) mr[d][a] = mr[d][a] ^ mr[d][b];
                else if (op == 4'h3) mr[d][a] = mr[d][b] + imm;
                else if (op == 4'h4) cmp = mr[d][a] >= mr[d][b];
                pc = (op == 4'h5 && cmp) ? int'(imm % 256) : (pc + 1) % 256;
                t += 4;
            end
        end
    endtask

    task automatic go(input int d, input int maxn);
        @(negedge clk);
        if (d == 0) begin st_a = 1; pa.delete(); end
        else begin st_b = 1; pb.delete(); end
        base[d] = cyc + 1;
        model(d, maxn);
        @(negedge clk);
        st_a = 0;
        st_b = 0;
    endtask

    task automatic wait_done(input int d);
        string n = d == 0 ? "a" : "b";
        for (int k = 0; k < 5000; k++) begin
            if (d == 0 ? done_a : done_b) break;
            @(negedge clk);
        end
        check({n, "_done_cycle"}, cyc, end_cyc[d] + 1);
        check({n, "_done"}, d == 0 ? done_a : done_b, 1);
        check({n, "_busy_after_end"}, d == 0 ? busy_a : busy_b, 0);
        check({n, "_queue_drained"}, d == 0 ? qa.size() : qb.size(), 0);
    endtask

    task automatic clear(input int d);
        for (int i = 0; i < 256; i++) begin
            if (d == 0) prog_a[i] = '0;
            else prog_b[i] = '0;
        end
    endtask

    task automatic rand_prog(input int d);
        int L = $urandom_range(8, 40);
        logic [31:0] w;
        logic [3:0] und [5] = '{4'h8, 4'h9, 4'hB, 4'hD, 4'hF};
        logic [3:0] mops [5] = '{4'h6, 4'h7, 4'hE, 4'hA, 4'hC};
        clear(d);
        for (int pc = 0; pc < L; pc++) begin
            case ($urandom_range(0, 9))
                0: w = ins(4'h2, 4'($urandom), 16'($urandom), 4'($urandom));
                1, 9: w = ins(4'h3, 4'($urandom), 16'($urandom), 4'($urandom));
                2: w = ins(4'h4, 4'($urandom), 16'($urandom), 4'($urandom));
                3: w = ins(4'h5, 4'($urandom), {8'($urandom), 8'($urandom_range(pc + 1, L))}, 4'($urandom));
                4, 5, 6: w = {mops[$urandom_range(0, 4)], 28'($urandom)};
                7: w = {4'h0, 28'($urandom)};
                default: w = {und[$urandom_range(0, 4)], 28'($urandom)};
            endcase
            if (d == 0) prog_a[pc] = w;
            else prog_b[pc] = w;
        end
        if (d == 0) prog_a[L] = ins(4'h1, 0, 0, 0);
        else prog_b[L] = ins(4'h1, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear(0);
        clear(1);
        mr = '{default: '0};
        repeat (3) @(negedge clk);
        check("rst_a_addr", addr_a, 0);
        check("rst_a_instr", io_a, 0);
        check("rst_a_valid", v_a, 0);
        check("rst_a_busy", busy_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_b_addr", addr_b, 0);
        check("rst_b_valid", v_b, 0);
        check("rst_b_busy", busy_b, 0);
        rst_a = 0;
        rst_b = 0;
        @(negedge clk);

        // SMA, six LOADIs, SENDL, END
        prog_a[0] = ins(4'h6, 0, 16'h0178, 0);
        for (int i = 0; i < 6; i++) prog_a[1 + i] = ins(4'h7, 4'(i), 16'(16'h8888 - i), 0);
        prog_a[7] = ins(4'hE, 0, 0, 0);
        prog_a[8] = ins(4'h1, 0, 0, 0);
        go(0, 100);
        @(negedge clk);
        check("t1_busy_at_first_f0", busy_a, 1);
        wait_done(0);
        check("t1_pulses", pa.size(), 8);

        // Loop program; re-run keeps r1 so the second run issues a single SMA
        clear(0);
        prog_a[0] = ins(4'h3, 2, 16'd2, 0);
        prog_a[1] = ins(4'h6, 0, 16'h017C, 0);
        prog_a[2] = ins(4'h3, 1, 16'd1, 1);
        prog_a[3] = ins(4'h4, 2, 0, 1);
        prog_a[4] = ins(4'h5, 0, 16'd1, 0);
        prog_a[5] = ins(4'h1, 0, 0, 0);
        go(0, 100);
        wait_done(0);
        check("loop_sma_count", pa.size(), 3);
        go(0, 100);
        repeat (5) @(negedge clk);
        st_a = 1;
        @(negedge clk);
        st_a = 0;
        wait_done(0);
        check("rerun_sma_count", pa.size(), 1);

        // Arithmetic edge cases: each taken JUMP skips a marker SMA
        clear(0);
        prog_a[0]  = ins(4'h3, 3, 16'hFFFF, 0);
        prog_a[1]  = ins(4'h3, 3, 16'h0001, 3);
        prog_a[2]  = ins(4'h4, 0, 0, 3);
        prog_a[3]  = ins(4'h5, 0, 16'd5, 0);
        prog_a[4]  = ins(4'h6, 0, 16'hDEAD, 0);
        prog_a[5]  = ins(4'h3, 4, 16'd7, 0);
        prog_a[6]  = ins(4'h2, 4, 0, 4);
        prog_a[7]  = ins(4'h4, 0, 0, 4);
        prog_a[8]  = ins(4'h5, 0, 16'hFF0A, 0);
        prog_a[9]  = ins(4'h6, 0, 16'hDEAD, 0);
        prog_a[10] = ins(4'h4, 0, 0, 0);
        prog_a[11] = ins(4'h5, 0, 16'd13, 0);
        prog_a[12] = ins(4'h6, 0, 16'hDEAD, 0);
        prog_a[13] = ins(4'h6, 0, 16'h0001, 0);
        prog_a[14] = ins(4'h1, 0, 0, 0);
        go(0, 100);
        wait_done(0);
        check("arith_sma_count", pa.size(), 1);

        // NOP and undefined opcode between two SMAs
        clear(0);
        prog_a[0] = ins(4'h6, 0, 16'h0111, 0);
        prog_a[1] = {4'h0, 28'hABCDEF1};
        prog_a[2] = {4'hF, 28'h1234567};
        prog_a[3] = ins(4'h6, 0, 16'h0222, 0);
        prog_a[4] = ins(4'h1, 0, 0, 0);
        go(0, 100);
        wait_done(0);
        check("nop_gap", pa.size() >= 2 ? pa[1] - pa[0] : -1, 12);

        // No END: pc wraps 255 -> 0
        clear(0);
        prog_a[0]   = ins(4'h6, 0, 16'hAAAA, 0);
        prog_a[255] = ins(4'h6, 0, 16'h5555, 0);
        go(0, 257);
        for (int k = 0; k < 1200 && qa.size() != 0; k++) @(negedge clk);
        check("wrap_pulses", pa.size(), 3);
        check("wrap_gap", pa.size() >= 3 ? pa[2] - pa[1] : -1, 4);
        check("wrap_still_busy", busy_a, 1);
        rst_a = 1;
        mr[0] = '{default: '0};
        qa.delete();
        @(negedge clk);
        rst_a = 0;

        // MEM_STALL=2, then reset during WRITEB EX
        prog_b[0] = ins(4'hE, 1, 16'h1234, 2);
        prog_b[1] = ins(4'hC, 3, 16'h5678, 4);
        prog_b[2] = ins(4'h1, 0, 0, 0);
        go(1, 100);
        for (int k = 0; k < 100 && cyc < base[1] + 9; k++) @(negedge clk);
        check("stall_writeb_valid", v_b, 1);
        #1 rst_b = 1;
        #1;
        check("stall_gap", pb.size() >= 2 ? pb[1] - pb[0] : -1, 6);
        check("rst_mid_valid", v_b, 0);
        check("rst_mid_instr", io_b, 0);
        check("rst_mid_addr", addr_b, 0);
        check("rst_mid_busy", busy_b, 0);
        check("rst_mid_done", done_b, 0);
        mr[1] = '{default: '0};
        qb.delete();
        @(negedge clk);
        rst_b = 0;

        for (int r = 0; r < 12; r++) begin
            rand_prog(r % 2);
            go(r % 2, 1000);
            wait_done(r % 2);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
